// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// pipe_hazard_ctrl_pkg: PC source codes and controller state encodings shared by the core.
// Revision 1.0
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] PC_SRC_RESET  = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP   = 2'b10;
   localparam logic [1:0] PC_SRC_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_RST  = 2'b00,
      ST_WARM = 2'b01,
      ST_RUN  = 2'b10,
      ST_TRAP = 2'b11
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// pipe_hazard_ctrl_if: hazard sources into the controller, PC mux / pipeline-register controls out.
// Revision 1.0
interface pipe_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] id_rs1_in;
   logic [REG_ADDR_W-1:0] id_rs2_in;
   logic                  ex_mem_read_in;
   logic [REG_ADDR_W-1:0] ex_rd_in;
   logic                  ex_branch_taken_in;
   logic                  mem_busy_in;
   logic                  trap_req_in;
   logic [1:0]            pc_src_out;
   logic                  pc_en_out;
   logic                  if_id_en_out;
   logic                  if_id_flush_out;
   logic                  id_ex_flush_out;
   logic                  ex_mem_flush_out;
   logic                  trap_ack_out;
   logic                  ready_out;

   modport master (
      output id_rs1_in, id_rs2_in, ex_mem_read_in, ex_rd_in,
             ex_branch_taken_in, mem_busy_in, trap_req_in,
      input  pc_src_out, pc_en_out, if_id_en_out, if_id_flush_out,
             id_ex_flush_out, ex_mem_flush_out, trap_ack_out, ready_out
   );

   modport slave (
      input  id_rs1_in, id_rs2_in, ex_mem_read_in, ex_rd_in,
             ex_branch_taken_in, mem_busy_in, trap_req_in,
      output pc_src_out, pc_en_out, if_id_en_out, if_id_flush_out,
             id_ex_flush_out, ex_mem_flush_out, trap_ack_out, ready_out
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// hazard_detect: combinational load-use comparison between the EX load and the ID sources.
// Revision 1.0
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  wire logic [REG_ADDR_W-1:0] i_id_rs1,
   input  wire logic [REG_ADDR_W-1:0] i_id_rs2,
   input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
   input  wire logic                  i_ex_mem_read,
   output logic                       o_load_use
);
   // x0 is hard-wired zero, so a load targeting it can never create a dependency.
   always_comb begin
      o_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                   ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
   end
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl: sequences start-up, load-use stalls, branch redirects, memory freezes and traps.
// Revision 1.0
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int WARMUP_CYCLES = 3,
   parameter int REG_ADDR_W    = 5
) (
   input  wire logic          clk_in,
   input  wire logic          rst_n_in,
   pipe_hazard_ctrl_if.slave  bus
);
   localparam int CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

   state_t           r_state;
   state_t           w_nxt_state;
   logic [CNT_W-1:0] r_warm_cnt;
   logic             w_load_use;

   logic [1:0]       w_pc_src;
   logic             w_pc_en;
   logic             w_if_id_en;
   logic             w_if_id_flush;
   logic             w_id_ex_flush;
   logic             w_ex_mem_flush;
   logic             w_trap_ack;
   logic             w_ready;

   hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard_detect (
      .i_id_rs1      (bus.id_rs1_in),
      .i_id_rs2      (bus.id_rs2_in),
      .i_ex_rd       (bus.ex_rd_in),
      .i_ex_mem_read (bus.ex_mem_read_in),
      .o_load_use    (w_load_use)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state    <= ST_RST;
         r_warm_cnt <= '0;
      end else begin
         r_state <= w_nxt_state;
         if (r_state == ST_WARM) begin
            r_warm_cnt <= r_warm_cnt + CNT_W'(1);
         end else begin
            r_warm_cnt <= '0;
         end
      end
   end

   always_comb begin
      w_nxt_state    = r_state;
      w_pc_src       = PC_SRC_SEQ;
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_trap_ack     = 1'b0;
      w_ready        = 1'b0;

      case (r_state)
         ST_RST: begin
            w_pc_src       = PC_SRC_RESET;
            w_pc_en        = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_nxt_state    = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARM;
         end
         ST_WARM: begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            if (r_warm_cnt == C_CNT_LAST) begin
               w_nxt_state = ST_RUN;
            end
         end
         ST_RUN: begin
            w_ready = 1'b1;
            // A memory freeze outranks everything; pending requests are held by their sources.
            if (bus.mem_busy_in) begin
               w_pc_en = 1'b0;
            end else if (bus.trap_req_in) begin
               w_id_ex_flush = 1'b1;
               w_nxt_state   = ST_TRAP;
            end else if (bus.ex_branch_taken_in) begin
               w_pc_src      = PC_SRC_BRANCH;
               w_pc_en       = 1'b1;
               w_if_id_en    = 1'b1;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
               w_id_ex_flush = 1'b1;
            end else begin
               w_pc_en    = 1'b1;
               w_if_id_en = 1'b1;
            end
         end
         ST_TRAP: begin
            w_pc_src       = PC_SRC_TRAP;
            w_pc_en        = 1'b1;
            w_if_id_en     = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_trap_ack     = 1'b1;
            w_nxt_state    = ST_RUN;
         end
         default: begin
            w_nxt_state = ST_RST;
         end
      endcase
   end

   assign bus.pc_src_out       = w_pc_src;
   assign bus.pc_en_out        = w_pc_en;
   assign bus.if_id_en_out     = w_if_id_en;
   assign bus.if_id_flush_out  = w_if_id_flush;
   assign bus.id_ex_flush_out  = w_id_ex_flush;
   assign bus.ex_mem_flush_out = w_ex_mem_flush;
   assign bus.trap_ack_out     = w_trap_ack;
   assign bus.ready_out        = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl: directed and random stimulus checked against a cycle-count based model.
// Revision 1.0
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam int W  = 3;
   localparam int AW = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   since_rel = 0;
   bit   trap_now  = 1'b0;
   bit   trap_pend = 1'b0;
   bit   was_ack;

   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.REG_ADDR_W(AW)) bus ();

   pipe_hazard_ctrl #(
      .WARMUP_CYCLES (W),
      .REG_ADDR_W    (AW)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs {pc_src, pc_en, if_id_en, if_id_fl, id_ex_fl, ex_mem_fl, ack, ready};
   // pc_src is masked to 00 whenever the PC is not loading.
   function automatic logic [8:0] model_out();
      logic [1:0] src;
      logic en, ifen, f1, f2, f3, ack, rdy, lu;
      src = PC_SRC_SEQ; en = 0; ifen = 0; f1 = 0; f2 = 0; f3 = 0; ack = 0; rdy = 0;
      lu = bus.ex_mem_read_in && (bus.ex_rd_in != 0) &&
           (bus.ex_rd_in == bus.id_rs1_in || bus.ex_rd_in == bus.id_rs2_in);
      if (!rst_n || since_rel == 0) begin
         src = PC_SRC_RESET; en = 1; f1 = 1; f2 = 1; f3 = 1;
      end else if (since_rel <= W) begin
         f1 = 1; f2 = 1; f3 = 1;
      end else if (trap_now) begin
         src = PC_SRC_TRAP; en = 1; ifen = 1; f1 = 1; f2 = 1; f3 = 1; ack = 1;
      end else begin
         rdy = 1;
         if (bus.mem_busy_in) begin
            en = 0;
         end else if (bus.trap_req_in) begin
            f2 = 1;
         end else if (bus.ex_branch_taken_in) begin
            src = PC_SRC_BRANCH; en = 1; ifen = 1; f1 = 1; f2 = 1;
         end else if (lu) begin
            f2 = 1;
         end else begin
            en = 1; ifen = 1;
         end
      end
      if (!en) src = 2'b00;
      return {src, en, ifen, f1, f2, f3, ack, rdy};
   endfunction

   function automatic logic [8:0] obs_out();
      return {(bus.pc_en_out ? bus.pc_src_out : 2'b00), bus.pc_en_out, bus.if_id_en_out,
              bus.if_id_flush_out, bus.id_ex_flush_out, bus.ex_mem_flush_out,
              bus.trap_ack_out, bus.ready_out};
   endfunction

   task automatic advance();
      if (!rst_n) begin
         since_rel = 0;
         trap_now  = 0;
      end else begin
         if (trap_now) trap_now = 0;
         else if (since_rel > W && !bus.mem_busy_in && bus.trap_req_in) trap_now = 1;
         if (since_rel < 1000) since_rel++;
      end
   endtask

   task automatic step(input string tag, output bit ack);
      logic [8:0] e;
      @(negedge clk);
      e = model_out();
      chk(tag, 32'(obs_out()), 32'(e));
      ack = e[1];
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic set_in(input int rs1, input int rs2, input bit mr, input int rd,
                         input bit br, input bit busy, input bit trap);
      bus.id_rs1_in          = AW'(rs1);
      bus.id_rs2_in          = AW'(rs2);
      bus.ex_mem_read_in     = mr;
      bus.ex_rd_in           = AW'(rd);
      bus.ex_branch_taken_in = br;
      bus.mem_busy_in        = busy;
      bus.trap_req_in        = trap;
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      step("in_reset0", was_ack);
      step("in_reset1", was_ack);
      rst_n = 1'b1;
      step("rel_cyc0", was_ack);
      for (int i = 1; i <= W; i++) step("warm", was_ack);
      step("first_run", was_ack);
      chk("ready_run", 32'(bus.ready_out), 32'd1);

      set_in(1, 5, 1, 5, 0, 0, 0);
      step("load_use", was_ack);
      set_in(1, 2, 0, 0, 0, 0, 0);
      step("after_lu", was_ack);
      set_in(0, 0, 1, 0, 0, 0, 0);
      step("lu_x0", was_ack);
      set_in(7, 3, 1, 7, 1, 0, 0);
      step("br_vs_lu", was_ack);
      set_in(0, 0, 0, 0, 0, 0, 0);
      step("plain_run", was_ack);

      set_in(0, 0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 4; i++) step("trap_busy", was_ack);
      set_in(0, 0, 0, 0, 1, 0, 1);
      step("trap_detect", was_ack);
      step("trap_cycle", was_ack);
      chk("trap_acked", 32'(was_ack), 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0);
      step("post_trap", was_ack);

      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
                $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), trap_pend);
         step("rand", was_ack);
         if (was_ack) trap_pend = 0;
         else if (!trap_pend && $urandom_range(0, 7) == 0) trap_pend = 1;
      end

      set_in(0, 0, 0, 0, 0, 0, 1);
      step("rst_trap_det", was_ack);
      #2;
      chk("in_trap", 32'(obs_out()), 32'(model_out()));
      rst_n = 1'b0;
      #1;
      chk("async_rst", 32'(obs_out()), 32'(model_out()));
      chk("async_ack", 32'(bus.trap_ack_out), 32'd0);
      chk("async_rdy", 32'(bus.ready_out), 32'd0);
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      advance();
      #1;
      step("held_rst", was_ack);
      rst_n = 1'b1;
      for (int i = 0; i <= W + 2; i++) step("re_warm", was_ack);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipelined core.
- Owns PC source selection, PC and IF/ID register enables, and per-stage flushes.
- Sequences post-reset start-up, load-use stalls, taken-branch redirects, memory-busy freezes and trap redirects.
- Sits between the hazard sources (ID/EX/MEM stage signals, trap requester) and the PC mux plus pipeline registers.

Parameters:
- WARMUP_CYCLES, 3, cycles the pipeline is held flushed after the reset vector load; 0 means no warm-up.
- REG_ADDR_W, 5, register-address width.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- id_rs1_in  input  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2_in  input  REG_ADDR_W  rs2 of the instruction in ID.
- ex_mem_read_in  input  1  instruction in EX is a load.
- ex_rd_in  input  REG_ADDR_W  destination register of the instruction in EX.
- ex_branch_taken_in  input  1  EX resolved a taken branch or jump.
- mem_busy_in  input  1  data memory not ready; whole pipeline must freeze.
- trap_req_in  input  1  level trap request; held by the requester until trap_ack_out.
- pc_src_out  output  2  00 reset vector, 01 branch target, 10 trap vector, 11 PC+4.
- pc_en_out  output  1  PC register load enable.
- if_id_en_out  output  1  IF/ID register load enable.
- if_id_flush_out  output  1  clear IF/ID to a bubble.
- id_ex_flush_out  output  1  clear ID/EX to a bubble.
- ex_mem_flush_out  output  1  clear EX/MEM to a bubble.
- trap_ack_out  output  1  single-cycle trap acknowledge.
- ready_out  output  1  pipeline in normal operation.

Behaviour:
- FSM states: RST, WARM, RUN, TRAP.
- State register and warm-up counter are async-cleared by rst_n_in=0.
- State is RST while rst_n_in=0 and for the first clock edge after release.
- RST outputs: pc_src=00, pc_en=1, if_id_en=0, all three flushes=1, trap_ack=0, ready=0.
  - Reset-vector load happens on the first edge after release.
  - Next state is WARM, or RUN if WARMUP_CYCLES=0.
- WARM outputs: pc_src=11, pc_en=0, if_id_en=0, all flushes=1, ready=0.
  - The counter runs 0..WARMUP_CYCLES-1; the state moves to RUN after exactly WARMUP_CYCLES cycles.
  - Counter width is clog2(WARMUP_CYCLES+1).
  - All hazard inputs are ignored in WARM.
- RUN is combinational on the inputs, with fixed priority (highest first):
  1. mem_busy_in=1: freeze. pc_en=0, if_id_en=0, no flushes. No trap ack, no branch action. Pending branch/trap inputs stay held by their sources.
  2. trap_req_in=1: pc_en=0, if_id_en=0, id_ex_flush=1. Next state is TRAP.
  3. ex_branch_taken_in=1: pc_src=01, pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1. A simultaneous load-use hazard is discarded because the ID instruction is wrong-path.
  4. Load-use hazard: ex_mem_read_in=1, ex_rd_in!=0, and ex_rd_in matches id_rs1_in or id_rs2_in. Outputs: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble per hazard; the hazard clears itself the next cycle.
  5. Otherwise: pc_src=11, pc_en=1, if_id_en=1, no flushes.
  - ready=1 throughout RUN.
- TRAP lasts exactly one cycle. Outputs: pc_src=10, pc_en=1, if_id_en=1, all three flushes=1, trap_ack=1, ready=0. Next state is RUN.
  - mem_busy_in in TRAP is ignored; the trap is committed.
- Unused pc_src values while pc_en=0 are driven 11; the verifier must not check them.
- No output is registered; all outputs are decoded from state and inputs in the same cycle.
- Reset asserted mid-operation, in any state, returns immediately to RST outputs.

Decomposition:
- Shared core package holds:
  - PC_SRC_RESET=2'b00, PC_SRC_BRANCH=2'b01, PC_SRC_TRAP=2'b10, PC_SRC_SEQ=2'b11 (also used by the PC mux);
  - FSM state encodings.
- One natural sub-module: hazard_detect. It is purely combinational load-use comparison with ports id_rs1/rs2, ex_rd, ex_mem_read, and output load_use. It is reused by the forwarding unit's tests.

Test Plan:
- Reset release, WARMUP_CYCLES=3: release rst_n_in.
  - Cycle 0: pc_src=00, pc_en=1, flushes=111.
  - Cycles 1-3: pc_en=0, flushes=111.
  - Cycle 4: ready=1, pc_src=11.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for one cycle.
  - That cycle: pc_en=0, if_id_en=0, id_ex_flush=1.
  - Repeat with ex_rd=0: no stall.
- Branch vs load-use collision: branch_taken=1 with a matching load-use.
  - Required: pc_src=01, pc_en=1, if_id_flush=1, id_ex_flush=1.
- Trap under memory busy: trap_req=1 with mem_busy=1 for 4 cycles.
  - Freeze, no ack.
  - Busy drops: next cycle is the detect cycle, then TRAP with pc_src=10, flushes=111, trap_ack=1 for one cycle, then RUN.
- Async reset mid-trap: pull rst_n_in low in TRAP between edges.
  - Outputs go to RST values immediately, with no clock edge.
  - trap_ack=0, ready=0.
